// File: rtl/dma_burst_gen_if.sv
// Burst request / completion channel between the DMA burst generator (master)
// and the memory-side engine that accepts bursts and reports their completion (slave).
interface dma_burst_gen_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  localparam int BPB = DATA_WIDTH / 8;

  logic                  req_valid_o;
  logic                  req_ready_i;
  logic [ADDR_WIDTH-1:0] req_addr_o;
  logic [7:0]            req_alen_o;
  logic [2:0]            req_size_o;
  logic [BPB-1:0]        req_strb_o;
  logic                  cmpl_valid_i;
  logic                  cmpl_err_i;

  modport master (
    output req_valid_o, req_addr_o, req_alen_o, req_size_o, req_strb_o,
    input  req_ready_i, cmpl_valid_i, cmpl_err_i
  );

  modport slave (
    input  req_valid_o, req_addr_o, req_alen_o, req_size_o, req_strb_o,
    output req_ready_i, cmpl_valid_i, cmpl_err_i
  );
endinterface

// File: rtl/dma_burst_gen.sv
// Splits a (base, length) transfer into AXI-style bursts that never cross a 4 KB
// boundary, limiting the number of outstanding bursts and draining them on stop.
module dma_burst_gen #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 64,
  parameter int BYTES_WIDTH  = 32,
  parameter int MAX_BEATS    = 256,
  parameter int MAX_PEND     = 8,
  parameter int MAX_BURST_EN = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  input  logic                       abort_i,
  input  logic [ADDR_WIDTH-1:0]      base_addr_i,
  input  logic [BYTES_WIDTH-1:0]     num_bytes_i,
  dma_burst_gen_if.master            bus,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       error_o,
  output logic [$clog2(MAX_PEND):0]  pend_o
);

  localparam int BPB = DATA_WIDTH / 8;
  localparam int SZ  = $clog2(BPB);
  localparam int PW  = $clog2(MAX_PEND) + 1;
  localparam int CAP = (MAX_BURST_EN != 0) ? MAX_BEATS : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                 r_state;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [BYTES_WIDTH-1:0] r_rem;
  logic                   r_valid;
  logic                   r_stop;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_err;
  logic [7:0]             r_alen;
  logic [BPB-1:0]         r_strb;
  logic [PW-1:0]          r_pend;

  logic [11:0]            w_off;
  logic [BYTES_WIDTH-1:0] w_rem;
  logic [BYTES_WIDTH-1:0] w_rem_mod;
  logic [BYTES_WIDTH-1:0] w_rem_beats;
  logic [BYTES_WIDTH-1:0] w_bound_beats;
  logic [BYTES_WIDTH-1:0] w_beats;
  logic [BYTES_WIDTH-1:0] w_bytes;
  logic                   w_last;
  logic [BPB-1:0]         w_strb;
  logic                   w_hs;
  logic                   w_cmpl;
  logic                   w_cerr;
  logic                   w_stop;
  logic                   w_misalign;
  logic [PW-1:0]          w_pend_nxt;
  logic                   w_pend_ok;

  // In IDLE the burst is sized straight from the start inputs so the first
  // request can be presented the cycle after start.
  always_comb begin
    w_off         = (r_state == IDLE) ? base_addr_i[11:0] : r_addr[11:0];
    w_rem         = (r_state == IDLE) ? num_bytes_i : r_rem;
    w_rem_mod     = w_rem & BYTES_WIDTH'(BPB - 1);
    w_rem_beats   = (w_rem >> SZ) + BYTES_WIDTH'(w_rem_mod != '0);
    w_bound_beats = BYTES_WIDTH'((13'd4096 - {1'b0, w_off}) >> SZ);
    w_beats       = w_rem_beats;
    if (w_bound_beats < w_beats) w_beats = w_bound_beats;
    if (BYTES_WIDTH'(CAP) < w_beats) w_beats = BYTES_WIDTH'(CAP);
    w_bytes       = w_beats << SZ;
    w_last        = (w_beats == w_rem_beats);
    for (int unsigned i = 0; i < BPB; i++) begin
      w_strb[i] = !w_last || (w_rem_mod == '0) || (BYTES_WIDTH'(i) < w_rem_mod);
    end
  end

  always_comb begin
    w_misalign = (base_addr_i & ADDR_WIDTH'(BPB - 1)) != '0;
    w_hs       = r_valid & bus.req_ready_i;
    w_cmpl     = bus.cmpl_valid_i && (r_pend != '0);
    w_cerr     = bus.cmpl_valid_i & bus.cmpl_err_i;
    w_stop     = r_stop | abort_i | w_cerr;
    case ({w_hs, w_cmpl})
      2'b10:   w_pend_nxt = r_pend + PW'(1);
      2'b01:   w_pend_nxt = r_pend - PW'(1);
      default: w_pend_nxt = r_pend;
    endcase
    w_pend_ok  = w_pend_nxt < PW'(MAX_PEND);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pend <= '0;
    else        r_pend <= w_pend_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
      r_valid <= 1'b0;
      r_stop  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_alen  <= '0;
      r_strb  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_addr <= base_addr_i;
            r_rem  <= num_bytes_i;
            r_err  <= w_misalign;
            r_stop <= 1'b0;
            r_busy <= 1'b1;
            if (w_misalign || (num_bytes_i == '0)) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ISSUE;
              r_valid <= 1'b1;
              r_alen  <= 8'(w_beats - BYTES_WIDTH'(1));
              r_strb  <= w_strb;
            end
          end
        end
        ISSUE: begin
          if (w_cerr) r_err <= 1'b1;
          if (w_hs) begin
            r_valid <= 1'b0;
            r_addr  <= r_addr + ADDR_WIDTH'(w_bytes);
            r_rem   <= w_last ? '0 : r_rem - w_bytes;
            if (w_last || w_stop) r_state <= DRAIN;
          end else if (!r_valid) begin
            if (w_stop) begin
              r_state <= DRAIN;
            end else if (w_pend_ok) begin
              r_valid <= 1'b1;
              r_alen  <= 8'(w_beats - BYTES_WIDTH'(1));
              r_strb  <= w_strb;
            end
          end else if (abort_i || w_cerr) begin
            // A presented request must still complete its handshake before stopping.
            r_stop <= 1'b1;
          end
        end
        DRAIN: begin
          if (w_cerr) r_err <= 1'b1;
          if (w_pend_nxt == '0) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_valid_o = r_valid;
  assign bus.req_addr_o  = r_addr;
  assign bus.req_alen_o  = r_alen;
  assign bus.req_size_o  = 3'(SZ);
  assign bus.req_strb_o  = r_strb;
  assign busy_o          = r_busy;
  assign done_o          = r_done;
  assign error_o         = r_err;
  assign pend_o          = r_pend;

endmodule

// File: tb/tb_dma_burst_gen.sv
// Self-checking bench: randomized handshake/completion timing against a burst-list
// reference model, plus directed corner cases on a default and a single-beat instance.
module tb_dma_burst_gen;
  localparam int AW = 32, DW = 64, BW = 32, BPB = 8, PEND = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start_i, abort_i;
  logic [AW-1:0] base_addr_i;
  logic [BW-1:0] num_bytes_i;
  logic          busy_o, done_o, error_o;
  logic [3:0]    pend_o;

  logic          s_start, s_abort;
  logic [AW-1:0] s_base;
  logic [BW-1:0] s_num;
  logic          s_busy, s_done, s_err;
  logic [3:0]    s_pend;

  dma_burst_gen_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  dma_burst_gen_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus2 ();

  dma_burst_gen #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTES_WIDTH(BW),
    .MAX_BEATS(256), .MAX_PEND(PEND), .MAX_BURST_EN(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
    .base_addr_i(base_addr_i), .num_bytes_i(num_bytes_i), .bus(bus),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .pend_o(pend_o)
  );

  dma_burst_gen #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTES_WIDTH(BW),
    .MAX_BEATS(256), .MAX_PEND(PEND), .MAX_BURST_EN(0)
  ) dut_sb (
    .clk(clk), .rst_n(rst_n), .start_i(s_start), .abort_i(s_abort),
    .base_addr_i(s_base), .num_bytes_i(s_num), .bus(bus2),
    .busy_o(s_busy), .done_o(s_done), .error_o(s_err), .pend_o(s_pend)
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  alen;
    logic [7:0]  strb;
  } burst_t;

  burst_t      exp_q[$];
  int unsigned n_pass = 0, n_total = 0;
  int unsigned n_exp, n_hs, outstanding, n_cmpl, done_cnt, hs_limit, cyc;
  int          err_at, abort_at;
  int unsigned rmode, cmode;
  logic        p_valid, p_ready, p_cmpl;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Expected burst list derived from the sizing rules: min(remaining, to-4KB, cap).
  function automatic void build_model(input logic [31:0] base, input int unsigned num,
                                      input int unsigned cap);
    longint unsigned a, r, beats, lim;
    burst_t b;
    a = base;
    r = num;
    while (r > 0) begin
      beats = (r + BPB - 1) / BPB;
      lim   = (4096 - (a % 4096)) / BPB;
      if (lim < beats) beats = lim;
      if (cap < beats) beats = cap;
      b.addr = a[31:0];
      b.alen = 8'(beats - 1);
      b.strb = (beats * BPB >= r && num % BPB != 0) ? 8'((1 << (num % BPB)) - 1) : 8'hFF;
      exp_q.push_back(b);
      a = a + beats * BPB;
      r = (beats * BPB >= r) ? 0 : r - beats * BPB;
    end
  endfunction

  task automatic cycle();
    logic rdy, cm, er;
    @(negedge clk);
    if (p_valid && p_ready) begin
      n_hs++;
      outstanding++;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    if (p_cmpl) outstanding--;
    if (bus.req_valid_o) begin
      if (exp_q.size() != 0) begin
        check("req_addr", bus.req_addr_o, exp_q[0].addr);
        check("req_alen", bus.req_alen_o, exp_q[0].alen);
        check("req_strb", bus.req_strb_o, exp_q[0].strb);
        check("req_size", bus.req_size_o, 3);
      end else begin
        check("extra_request", n_hs + 1, n_exp);
      end
    end
    if (p_valid && !p_ready) check("hold_valid", bus.req_valid_o, 1);
    check("pend", pend_o, outstanding);
    if (pend_o == PEND) check("valid_at_full", bus.req_valid_o, 0);
    if (done_o) done_cnt++;
    p_valid = bus.req_valid_o;
    rdy = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    cm  = (outstanding > 0) && (cmode == 1 || (cmode == 2 && $urandom_range(0, 2) == 0));
    er  = cm && (int'(n_cmpl) == err_at);
    if (er) hs_limit = n_hs + (bus.req_valid_o ? 1 : 0);
    if (cm) n_cmpl++;
    abort_i = (int'(cyc) == abort_at);
    if (abort_i) hs_limit = n_hs + (bus.req_valid_o ? 1 : 0);
    cyc++;
    start_i = 1'b0;
    bus.req_ready_i  = rdy;
    bus.cmpl_valid_i = cm;
    bus.cmpl_err_i   = er;
    p_ready = rdy;
    p_cmpl  = cm;
  endtask

  task automatic start_job(input logic [31:0] base, input int unsigned num,
                           input int unsigned rm, input int unsigned cm,
                           input int ea, input int aa);
    exp_q.delete();
    if (base % BPB == 0 && num != 0) build_model(base, num, 256);
    n_exp = exp_q.size();
    n_hs = 0; n_cmpl = 0; done_cnt = 0; hs_limit = n_exp; cyc = 0;
    err_at = ea; abort_at = aa; rmode = rm; cmode = cm;
    cycle();
    start_i = 1'b1;
    base_addr_i = base;
    num_bytes_i = num;
    cycle();
    check("start_latency", bus.req_valid_o, n_exp > 0);
    check("busy_after_start", busy_o, 1);
  endtask

  task automatic finish_job(input logic exp_err);
    for (int i = 0; i < 5000 && done_cnt == 0; i++) cycle();
    check("done_seen", done_cnt, 1);
    check("error_at_done", error_o, exp_err);
    if (hs_limit < n_exp) begin
      check("no_bursts_after_stop", n_hs <= hs_limit, 1);
    end else begin
      check("burst_total", n_hs, n_exp);
    end
    cycle();
    check("idle_busy", busy_o, 0);
    check("done_width", done_o, 0);
    check("error_hold", error_o, exp_err);
    cycle();
    cycle();
    check("done_once", done_cnt, 1);
  endtask

  initial begin
    int unsigned h2;
    logic pv2;
    start_i = 0; abort_i = 0; base_addr_i = '0; num_bytes_i = '0;
    s_start = 0; s_abort = 0; s_base = '0; s_num = '0;
    bus.req_ready_i = 0; bus.cmpl_valid_i = 0; bus.cmpl_err_i = 0;
    bus2.req_ready_i = 0; bus2.cmpl_valid_i = 0; bus2.cmpl_err_i = 0;
    p_valid = 0; p_ready = 0; p_cmpl = 0; outstanding = 0;
    err_at = -1; abort_at = -1; rmode = 0; cmode = 0;
    repeat (3) @(negedge clk);
    check("rst_valid", bus.req_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_error", error_o, 0);
    check("rst_pend", pend_o, 0);
    check("rst_size", bus.req_size_o, 3);
    rst_n = 1'b1;

    start_job(32'h1000, 4096, 0, 1, -1, -1); finish_job(1'b0);
    start_job(32'h0FF0, 64, 0, 1, -1, -1);   finish_job(1'b0);
    start_job(32'h2000, 20, 0, 1, -1, -1);   finish_job(1'b0);
    start_job(32'h2000, 0, 0, 1, -1, -1);    finish_job(1'b0);
    start_job(32'h1004, 64, 0, 1, -1, -1);   finish_job(1'b1);
    start_job(32'h0000, 5 * 4096, 0, 1, 0, -1); finish_job(1'b1);
    start_job(32'h0000, 8192, 1, 2, -1, 4);  finish_job(1'b0);
    start_job(32'h0100, 64, 0, 1, -1, -1);   finish_job(1'b0);
    for (int j = 0; j < 6; j++) begin
      start_job($urandom_range(0, 32'h3FFF) & 32'hFFFF_FFF8, $urandom_range(1, 6000), 1, 2, -1, -1);
      finish_job(1'b0);
    end

    bus.cmpl_valid_i = 1'b1;
    @(negedge clk);
    bus.cmpl_valid_i = 1'b0;
    check("cmpl_at_zero_ignored", pend_o, 0);

    // Single-beat instance: stall at the outstanding limit, then release one slot.
    bus2.req_ready_i = 1'b1;
    s_base = 32'h100; s_num = 80; s_start = 1'b1;
    h2 = 0; pv2 = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pv2 && bus2.req_ready_i) h2++;
      pv2 = bus2.req_valid_o;
      s_start = 1'b0;
    end
    check("sb_hs_at_full", h2, 8);
    check("sb_pend_full", s_pend, 8);
    check("sb_valid_low", bus2.req_valid_o, 0);
    check("sb_alen", bus2.req_alen_o, 0);
    bus2.cmpl_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (pv2 && bus2.req_ready_i) h2++;
      pv2 = bus2.req_valid_o;
      bus2.cmpl_valid_i = 1'b0;
    end
    check("sb_ninth", h2, 9);
    check("sb_pend_refill", s_pend, 8);
    for (int i = 0; i < 200 && !s_done; i++) begin
      @(negedge clk);
      if (pv2 && bus2.req_ready_i) h2++;
      pv2 = bus2.req_valid_o;
      bus2.cmpl_valid_i = (s_pend != 0);
    end
    bus2.cmpl_valid_i = 1'b0;
    check("sb_done", s_done, 1);
    check("sb_total", h2, 10);
    check("sb_error", s_err, 0);

    // Reset mid-transfer with a request presented and three bursts outstanding.
    start_job(32'h0, 16384, 0, 0, -1, -1);
    for (int i = 0; i < 40 && pend_o != 3; i++) cycle();
    bus.req_ready_i = 1'b0;
    p_ready = 1'b0;
    rmode = 2;
    cycle();
    check("pre_rst_valid", bus.req_valid_o, 1);
    check("pre_rst_pend", pend_o, 3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", bus.req_valid_o, 0);
    check("arst_busy", busy_o, 0);
    check("arst_done", done_o, 0);
    check("arst_error", error_o, 0);
    check("arst_pend", pend_o, 0);
    check("arst_addr", bus.req_addr_o, 0);
    check("arst_alen", bus.req_alen_o, 0);
    check("arst_strb", bus.req_strb_o, 0);
    check("arst_size", bus.req_size_o, 3);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    n_exp = 0; n_hs = 0; done_cnt = 0; outstanding = 0;
    p_valid = 0; p_cmpl = 0; rmode = 0; cmode = 0;
    repeat (4) cycle();
    check("no_done_after_rst", done_cnt, 0);
    check("idle_after_rst", busy_o, 0);
    start_job(32'h3008, 1000, 1, 2, -1, -1);
    finish_job(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/dma_burst_gen.md
DMA_BURST_GEN -- requirements
Module: dma_burst_gen

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, AXI data width (bytes per beat BPB = DATA_WIDTH/8, power of 2).
REQ-003 SHALL have parameter BYTES_WIDTH, default 32, transfer byte-count width.
REQ-004 SHALL have parameter MAX_BEATS, default 256, beats per burst (1..256).
REQ-005 SHALL have parameter MAX_PEND, default 8, outstanding bursts (power of 2).
REQ-006 SHALL have parameter MAX_BURST_EN, default 1; 0 forces single-beat bursts.
REQ-007 SHALL have ports: clk in 1 clock; rst_n in 1 reset, asynchronous, active-low.
REQ-008 SHALL have ports: start_i in 1 start pulse; abort_i in 1 stop request; base_addr_i in ADDR_WIDTH start address; num_bytes_i in BYTES_WIDTH transfer length.
REQ-009 SHALL have ports: req_valid_o out 1; req_ready_i in 1; req_addr_o out ADDR_WIDTH; req_alen_o out 8 (beats-1); req_size_o out 3 (log2 BPB); req_strb_o out BPB (last-beat strobe).
REQ-010 SHALL have ports: cmpl_valid_i in 1 burst completed; cmpl_err_i in 1 completion error (qualified by cmpl_valid_i).
REQ-011 SHALL have ports: busy_o out 1; done_o out 1 one-cycle pulse; error_o out 1; pend_o out clog2(MAX_PEND)+1 outstanding count.

Function
REQ-012 SHALL implement states IDLE, ISSUE, DRAIN, DONE; busy_o=1 outside IDLE.
REQ-013 SHALL ignore start_i outside IDLE; in IDLE, start_i latches base_addr_i, num_bytes_i, clears error_o, enters ISSUE next cycle.
REQ-014 SHALL, on start with base_addr_i not BPB-aligned, issue no request, set error_o, go DONE.
REQ-015 SHALL, on start with num_bytes_i=0, issue no request, go DONE with error_o=0.
REQ-016 SHALL compute burst beats = min(remaining beats ceil(rem/BPB), beats to next 4 KB boundary (4096-addr[11:0])/BPB, MAX_BEATS, or 1 if MAX_BURST_EN=0).
REQ-017 SHALL drive req_alen_o = beats-1; no burst crosses a 4 KB boundary.
REQ-018 SHALL drive req_strb_o all-ones except the final burst when num_bytes%BPB!=0: low (num_bytes%BPB) bits set.
REQ-019 SHALL, on handshake (req_valid_o & req_ready_i), advance addr by beats*BPB and reduce remaining by beats*BPB, saturating at 0.
REQ-020 SHALL hold req_addr_o/alen/size/strb stable and req_valid_o high from assertion until handshake.
REQ-021 SHALL not assert req_valid_o when pend_o==MAX_PEND; may assert the cycle after pend drops.
REQ-022 SHALL increment pend_o on handshake, decrement on cmpl_valid_i, hold when both in same cycle; cmpl_valid_i at pend_o=0 ignored (no underflow).
REQ-023 SHALL move ISSUE->DRAIN after the handshake consuming the last bytes, or after abort_i / cmpl_err_i (any currently asserted req_valid_o completes its handshake first).
REQ-024 SHALL latch error_o on cmpl_valid_i & cmpl_err_i in ISSUE or DRAIN; abort alone leaves error_o=0.
REQ-025 SHALL move DRAIN->DONE when pend_o==0 (including cycle where final completion arrives, decremented value).
REQ-026 SHALL pulse done_o for one cycle in DONE, then return to IDLE; error_o holds until next accepted start.
REQ-027 SHALL give one-cycle start-to-first-req_valid_o latency when pend_o<MAX_PEND.

Reset
REQ-028 SHALL, on rst_n low, immediately force IDLE, req_valid_o=0, done_o=0, error_o=0, busy_o=0, pend_o=0, req_addr_o=0, req_alen_o=0, req_strb_o=0, req_size_o=log2(BPB).
REQ-029 SHALL discard in-flight state on reset mid-transfer; no done_o pulse on reset release.

Verification
REQ-030 base 0x1000, num 4096, ready=1, immediate completions -> bursts (0x1000,alen 255),(0x1800,alen 255), strb 0xFF, done_o once, error_o 0.
REQ-031 base 0x0FF0, num 64 -> (0x0FF0,alen 1),(0x1000,alen 5).
REQ-032 base 0x2000, num 20 -> single burst alen 2, strb 0x0F.
REQ-033 MAX_BURST_EN=0, num 80, no completions -> exactly 8 handshakes, pend_o=8, req_valid_o low; one cmpl_valid_i -> 9th request, pend stays 8.
REQ-034 cmpl_err_i on 1st completion of 10-burst job -> no new bursts after current handshake, drain to pend 0, done_o with error_o=1; base 0x1004 -> no requests, done_o+error_o.
REQ-035 rst_n low while req_valid_o=1 and pend_o=3 -> all outputs per REQ-028 same cycle; new start after release runs normally.
